// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline controller: PC/IF-IF/ID enables, NOP flush and ID/EX bubble from load-use, branch and fetch stalls.
// Optional stall/flush statistics counters are compiled in with `define HAZARD_STATS_EN.
module if_id_hazard_ctrl #(
  parameter int IMEM_TIMEOUT = 15
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       imem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       imem_timeout
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_count
  , output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int WCW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO_MAX = WCW'(IMEM_TIMEOUT);

  // BOOT: one cycle after reset | RUN: normal | FLUSH: squash wrong-path fetch | IMEM_WAIT: fetch stalled
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, IMEM_WAIT} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           tmo_q, tmo_d, tmo_now;
  logic           lu;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    tmo_now      = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_q)
      BOOT: begin
        pc_write     = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        wcnt_d       = '0;
        state_d      = RUN;
      end
      default: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          wcnt_d       = '0;
          state_d      = FLUSH;
        end else if (state_q == FLUSH) begin
          pc_write    = imem_ready;
          if_id_flush = 1'b1;
          wcnt_d      = '0;
          state_d     = RUN;
        end else begin
          if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end
          // The wait counter tracks fetch stalls even while a load-use stall owns the outputs
          if (imem_ready) begin
            wcnt_d  = '0;
            state_d = RUN;
          end else begin
            wcnt_d  = (wcnt_q == TMO_MAX) ? wcnt_q : wcnt_q + WCW'(1);
            tmo_now = (wcnt_d == TMO_MAX);
            state_d = IMEM_WAIT;
          end
        end
      end
    endcase
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      tmo_now      = 1'b0;
    end
  end

  assign tmo_d        = tmo_q | tmo_now;
  assign imem_timeout = tmo_q | tmo_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             redirect;

  assign redirect = ex_branch_taken && (state_q != BOOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state_q != BOOT) && !pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (redirect && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Self-checking bench for if_id_hazard_ctrl: per-cycle behavioural model plus directed literal checks.
// Statistics checks are included when HAZARD_STATS_EN is defined.
module tb_if_id_hazard_ctrl;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, imem_timeout;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
`endif

  int checks = 0;
  int failures = 0;

  if_id_hazard_ctrl #(.IMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .imem_timeout(imem_timeout)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble};
  endfunction

  // ---------------- behavioural model ----------------
  logic m_boot = 1'b1, m_squash = 1'b0, m_tmo = 1'b0;
  int   m_wait = 0, m_stall = 0, m_flush = 0;

  function automatic logic hazard();
    if (!ex_mem_read || ex_rd == 5'd0) return 1'b0;
    return (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    logic       counting, etmo;
    int         nwait;
    counting = 1'b0;
    nwait    = 0;
    if (!reset_n)             e = 4'b0011;
    else if (m_boot)          e = 4'b0111;
    else if (ex_branch_taken) e = 4'b1111;
    else if (m_squash)        e = {imem_ready, 3'b110};
    else if (hazard())        e = 4'b0001;
    else if (!imem_ready)     e = 4'b0110;
    else                      e = 4'b1100;
    if (reset_n && !m_boot && !ex_branch_taken && !m_squash && !imem_ready) begin
      counting = 1'b1;
      nwait    = (m_wait + 1 > TMO) ? TMO : m_wait + 1;
    end
    etmo = reset_n && (m_tmo || (counting && nwait >= TMO));
    chk("model_outs", {28'd0, outs()}, {28'd0, e});
    chk("model_timeout", {31'd0, imem_timeout}, {31'd0, etmo});
`ifdef HAZARD_STATS_EN
    chk("model_stall_count", {16'd0, stall_count}, m_stall);
    chk("model_flush_count", {16'd0, flush_count}, m_flush);
`endif
    if (!reset_n) begin
      m_boot = 1'b1; m_squash = 1'b0; m_tmo = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!m_boot && !e[3]) m_stall++;
      m_tmo = etmo;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (ex_branch_taken) begin
        m_squash = 1'b1; m_wait = 0; m_flush++;
      end else if (m_squash) begin
        m_squash = 1'b0; m_wait = 0;
      end else begin
        m_wait = counting ? nwait : 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic br, input logic rdy, input logic mr, input logic [4:0] erd,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    @(posedge clk);
    #1;
    ex_branch_taken = br; imem_ready = rdy; ex_mem_read = mr; ex_rd = erd;
    id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, rdy, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic lit(input string name, input logic [3:0] e, input logic etmo);
    chk(name, {28'd0, outs()}, {28'd0, e});
    chk({name, "_tmo"}, {31'd0, imem_timeout}, {31'd0, etmo});
  endtask

  initial begin
    reset_n = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1; ex_mem_read = 1'b0; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      lit("reset", 4'b0011, 1'b0);
    end
    @(posedge clk); #1; reset_n = 1'b1; #1;
    lit("boot", 4'b0111, 1'b0);
    idle(1'b1); lit("run", 4'b1100, 1'b0);

    // load-use hazards
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); lit("lu_rs1", 4'b0001, 1'b0);
    idle(1'b1); lit("lu_clear", 4'b1100, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1); lit("lu_rd0", 4'b1100, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1); lit("lu_rs2", 4'b0001, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0); lit("lu_unused", 4'b1100, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); lit("lu_noload", 4'b1100, 1'b0);

    // branch redirect
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); lit("br_run", 4'b1111, 1'b0);
    idle(1'b1); lit("br_flush", 4'b1110, 1'b0);
    idle(1'b1); lit("br_back", 4'b1100, 1'b0);

    // short fetch stall
    for (int k = 1; k <= 4; k++) begin
      idle(1'b0); lit("wait4", 4'b0110, 1'b0);
    end
    idle(1'b1); lit("wait4_done", 4'b1100, 1'b0);

    // long fetch stall -> sticky timeout
    for (int k = 1; k <= 20; k++) begin
      idle(1'b0); lit($sformatf("wait20_%0d", k), 4'b0110, k >= TMO);
    end
    idle(1'b1); lit("wait20_done", 4'b1100, 1'b1);
    idle(1'b1); lit("tmo_sticky", 4'b1100, 1'b1);

    // load-use together with branch
    drive(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); lit("lu_br", 4'b1111, 1'b1);
    idle(1'b1); lit("lu_br_flush", 4'b1110, 1'b1);
    // branch while in FLUSH, then FLUSH with fetch not ready
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); lit("br_a", 4'b1111, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); lit("br_in_flush", 4'b1111, 1'b1);
    idle(1'b0); lit("flush_notready", 4'b0110, 1'b1);
    idle(1'b1); lit("after_flush", 4'b1100, 1'b1);

    // load-use with fetch stall, in RUN and in IMEM_WAIT
    drive(1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0); lit("lu_nr_run", 4'b0001, 1'b1);
    idle(1'b1); lit("lu_nr_done", 4'b1100, 1'b1);
    idle(1'b0); lit("wait_a", 4'b0110, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1); lit("lu_in_wait", 4'b0001, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); lit("br_in_wait", 4'b1111, 1'b1);
    idle(1'b1); lit("br_in_wait_flush", 4'b1110, 1'b1);

    // reset mid-operation
    idle(1'b0); lit("pre_reset", 4'b0110, 1'b1);
    @(posedge clk); #1; reset_n = 1'b0; #1;
    lit("mid_reset", 4'b0011, 1'b0);
    @(posedge clk); #1; reset_n = 1'b1; imem_ready = 1'b1; #1;
    lit("reboot", 4'b0111, 1'b0);
    idle(1'b1); lit("rerun", 4'b1100, 1'b0);
    idle(1'b1);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
